rfetch_hazard_ctrl: RTL and testbench
=====================================

Name: rfetch_hazard_ctrl

Overview:
Scoreboard-based hazard controller that sequences the register-fetch stage. It tracks in-flight writes to each architectural register, from issue out of rfetch until regfile writeback or squash. It drives the rfetch stall_v_i when a source operand or destination slot is not ready. It sits beside rfetch_stage: it consumes the decoded rs1/rs2/rd of the cword held there and the regfile write port signals.

Parameters:
els_p, 32, number of architectural registers; register 0 is hardwired zero and never tracked
inflight_p, 3, max outstanding writes per register; counter width = $clog2(inflight_p+1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
issue_v_i  in  1  valid instruction present in rfetch this cycle
issue_rd_w_v_i  in  1  that instruction writes rd
issue_rd_i  in  $clog2(els_p)  destination register
rs1_v_i  in  1  instruction reads rs1
rs1_i  in  $clog2(els_p)  source 1
rs2_v_i  in  1  instruction reads rs2
rs2_i  in  $clog2(els_p)  source 2
flush_i  in  1  squash instruction in rfetch this cycle (branch redirect)
wb_v_i  in  1  regfile write this cycle (same as regfile rd_w_v_i)
wb_rd_i  in  $clog2(els_p)  writeback register
kill_v_i  in  1  an issued, in-flight writer was squashed downstream
kill_rd_i  in  $clog2(els_p)  rd of killed writer
stall_v_o  out  1  stall rfetch (drives rfetch stall_v_i)
busy_o  out  els_p  bit i = cnt[i] != 0
error_o  out  1  sticky: decrement of a zero counter observed

Behaviour:
- Reset: all cnt[i]=0, busy_o=0, error_o=0. stall_v_o forced 1 while rst_i high; rst_i overrides all other inputs in the same cycle.
- Combinational hazard terms:
  - raw1 = rs1_v_i & rs1_i!=0 & cnt[rs1_i]!=0
  - raw2 = same for rs2
  - sat = issue_rd_w_v_i & issue_rd_i!=0 & cnt[issue_rd_i]==inflight_p
- stall_v_o = issue_v_i & ~flush_i & (raw1|raw2|sat). Zero-cycle latency from inputs.
- No same-cycle writeback bypass: a source whose wb_v_i arrives this cycle still stalls; the counter clears on the next edge and the stall drops one cycle later.
- accept = issue_v_i & ~flush_i & ~stall_v_o. inc = accept & issue_rd_w_v_i & issue_rd_i!=0.
- dec_wb = wb_v_i & wb_rd_i!=0; dec_kill = kill_v_i & kill_rd_i!=0.
- Per register, next cnt = cnt + inc_hit - dec_wb_hit - dec_kill_hit, evaluated in one update. Simultaneous inc and dec on the same register gives net 0. wb and kill on the same register decrement by 2.
- Underflow: if the decrement exceeds cnt, the result clamps to 0 and error_o sets. error_o clears only on reset.
- Increment is never applied at cnt==inflight_p; sat stall prevents it.
- Writes to register 0 via issue, wb or kill are ignored; cnt[0] stays 0.
- flush_i suppresses stall and increment for the current cycle only. Counters for already-issued writers persist until wb or kill.
- busy_o is registered state, updated on the same edge as cnt.

Optional Feature:
Macro RVGA_HAZARD_PERF_EN.
- Defined: adds output stall_cnt_o (32 bits). It increments each cycle stall_v_o=1 and rst_i=0, wraps at 2^32, and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then issue rd=5 (no sources) -> stall_v_o=0; next cycle busy_o[5]=1.
- Issue rd=5, then next instr rs1=5 -> stall_v_o=1. Assert wb_v_i rd=5 -> stall stays 1 that cycle and drops to 0 the following cycle; busy_o[5]=0.
- Three issues to rd=7 with no wb (inflight_p=3), then a fourth issue rd=7 -> stall_v_o=1 via sat. One wb rd=7 -> the fourth issues next cycle; cnt[7] returns to 3.
- Same cycle: issue rd=9 accepted and wb rd=9 with cnt[9]=1 -> cnt[9] stays 1, busy_o[9]=1.
- Issue rd=0 and rs1=0 -> no stall, busy_o[0]=0. wb rd=3 with cnt[3]=0 -> error_o=1, which persists until rst_i.
- flush_i=1 with a pending raw hazard -> stall_v_o=0 and no increment. With RVGA_HAZARD_PERF_EN, 4 stall cycles -> stall_cnt_o=4.

Source files
------------

// File: rtl/rfetch_hazard_ctrl.sv
// rfetch_hazard_ctrl: per-register in-flight write scoreboard that stalls rfetch on RAW or saturation hazards.
// Optional RVGA_HAZARD_PERF_EN adds stall_cnt_o, a free-running count of stall cycles.
module rfetch_hazard_ctrl #(
  parameter int els_p      = 32,
  parameter int inflight_p = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_v_i,
  input  logic                      issue_rd_w_v_i,
  input  logic [$clog2(els_p)-1:0]  issue_rd_i,
  input  logic                      rs1_v_i,
  input  logic [$clog2(els_p)-1:0]  rs1_i,
  input  logic                      rs2_v_i,
  input  logic [$clog2(els_p)-1:0]  rs2_i,
  input  logic                      flush_i,
  input  logic                      wb_v_i,
  input  logic [$clog2(els_p)-1:0]  wb_rd_i,
  input  logic                      kill_v_i,
  input  logic [$clog2(els_p)-1:0]  kill_rd_i,
  output logic                      stall_v_o,
  output logic [els_p-1:0]          busy_o,
  output logic                      error_o
`ifdef RVGA_HAZARD_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);
  localparam int aw  = $clog2(els_p);
  localparam int cw  = $clog2(inflight_p + 1);
  localparam int cw1 = cw + 1;

  logic [cw-1:0]    r_cnt   [els_p];
  logic [cw-1:0]    w_cnt_n [els_p];
  logic [els_p-1:0] w_busy_n;
  logic [cw:0]      w_up;
  logic [cw:0]      w_dn;
  logic w_raw1, w_raw2, w_sat, w_haz, w_inc, w_dec_wb, w_dec_kill, w_under;

  assign w_raw1     = rs1_v_i && rs1_i != '0 && r_cnt[rs1_i] != '0;
  assign w_raw2     = rs2_v_i && rs2_i != '0 && r_cnt[rs2_i] != '0;
  assign w_sat      = issue_rd_w_v_i && issue_rd_i != '0 && r_cnt[issue_rd_i] == cw'(inflight_p);
  assign w_haz      = issue_v_i && !flush_i && (w_raw1 || w_raw2 || w_sat);
  assign stall_v_o  = rst_i || w_haz;
  assign w_inc      = issue_v_i && !flush_i && !w_haz && issue_rd_w_v_i && issue_rd_i != '0;
  assign w_dec_wb   = wb_v_i && wb_rd_i != '0;
  assign w_dec_kill = kill_v_i && kill_rd_i != '0;

  // Increment and both decrements fold into one update; over-decrement clamps to zero and flags error.
  always_comb begin
    w_cnt_n  = r_cnt;
    w_busy_n = '0;
    w_under  = 1'b0;
    w_up     = '0;
    w_dn     = '0;
    for (int i = 1; i < els_p; i++) begin
      w_up        = {1'b0, r_cnt[i]} + cw1'(w_inc && issue_rd_i == aw'(i));
      w_dn        = cw1'(w_dec_wb && wb_rd_i == aw'(i)) + cw1'(w_dec_kill && kill_rd_i == aw'(i));
      w_under     = w_under || (w_dn > w_up);
      w_cnt_n[i]  = (w_dn > w_up) ? '0 : cw'(w_up - w_dn);
      w_busy_n[i] = w_cnt_n[i] != '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < els_p; i++) r_cnt[i] <= '0;
      busy_o  <= '0;
      error_o <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_n;
      busy_o  <= w_busy_n;
      error_o <= error_o || w_under;
    end
  end

`ifdef RVGA_HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_stall_cnt <= '0;
    else if (w_haz) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_rfetch_hazard_ctrl.sv
// tb_rfetch_hazard_ctrl: scenario tasks drive rfetch_hazard_ctrl; a reference model queues expected stall/busy/error.
module tb_rfetch_hazard_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic issue_v_i = 0, issue_rd_w_v_i = 0, rs1_v_i = 0, rs2_v_i = 0, flush_i = 0, wb_v_i = 0, kill_v_i = 0;
  logic [4:0] issue_rd_i = 0, rs1_i = 0, rs2_i = 0, wb_rd_i = 0, kill_rd_i = 0;
  logic stall_v_o, error_o;
  logic [31:0] busy_o;
`ifdef RVGA_HAZARD_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  rfetch_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_v_i(issue_v_i), .issue_rd_w_v_i(issue_rd_w_v_i), .issue_rd_i(issue_rd_i),
    .rs1_v_i(rs1_v_i), .rs1_i(rs1_i), .rs2_v_i(rs2_v_i), .rs2_i(rs2_i),
    .flush_i(flush_i), .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i),
    .kill_v_i(kill_v_i), .kill_rd_i(kill_rd_i),
    .stall_v_o(stall_v_o), .busy_o(busy_o), .error_o(error_o)
`ifdef RVGA_HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    bit iv; bit wv; bit [4:0] rd;
    bit r1v; bit [4:0] r1; bit r2v; bit [4:0] r2;
    bit fl; bit wbv; bit [4:0] wbrd; bit kv; bit [4:0] krd;
  } stim_t;

  int total = 0;
  int bad = 0;
  int m_cnt [32];
  bit m_err;
  bit q_s [$];
  logic [31:0] q_b [$];
  bit q_e [$];

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    return t;
  endfunction
  function automatic stim_t iss(int rd);
    stim_t t;
    t = '0; t.iv = 1; t.wv = 1; t.rd = 5'(rd);
    return t;
  endfunction
  function automatic stim_t rd1(int r);
    stim_t t;
    t = '0; t.iv = 1; t.r1v = 1; t.r1 = 5'(r);
    return t;
  endfunction
  function automatic stim_t wb(int r);
    stim_t t;
    t = '0; t.wbv = 1; t.wbrd = 5'(r);
    return t;
  endfunction

  // Drive one cycle and queue the model's expected stall and post-edge busy/error.
  task automatic d(input stim_t t);
    bit st;
    bit acc;
    int up;
    int dn;
    logic [31:0] b;
    @(negedge clk_i);
    issue_v_i = t.iv; issue_rd_w_v_i = t.wv; issue_rd_i = t.rd;
    rs1_v_i = t.r1v; rs1_i = t.r1; rs2_v_i = t.r2v; rs2_i = t.r2;
    flush_i = t.fl; wb_v_i = t.wbv; wb_rd_i = t.wbrd; kill_v_i = t.kv; kill_rd_i = t.krd;
    st = t.iv && !t.fl && ((t.r1v && t.r1 != 0 && m_cnt[t.r1] != 0) ||
                           (t.r2v && t.r2 != 0 && m_cnt[t.r2] != 0) ||
                           (t.wv && t.rd != 0 && m_cnt[t.rd] == 3));
    acc = t.iv && !t.fl && !st;
    b = '0;
    for (int i = 1; i < 32; i++) begin
      up = m_cnt[i] + int'(acc && t.wv && t.rd == 5'(i));
      dn = int'(t.wbv && t.wbrd == 5'(i)) + int'(t.kv && t.krd == 5'(i));
      if (dn > up) begin m_cnt[i] = 0; m_err = 1; end
      else m_cnt[i] = up - dn;
      b[i] = m_cnt[i] != 0;
    end
    q_s.push_back(st); q_b.push_back(b); q_e.push_back(m_err);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1; issue_v_i = 1; issue_rd_w_v_i = 1; issue_rd_i = 4; rs1_v_i = 1; rs1_i = 4;
    wb_v_i = 1; wb_rd_i = 3; kill_v_i = 1; kill_rd_i = 6;
    #1 total++;
    if (stall_v_o !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b exp=1", stall_v_o); end
    @(posedge clk_i); #1 total++;
    if (busy_o !== 32'h0 || error_o !== 1'b0) begin
      bad++; $display("FAIL reset_state busy=%h err=%b exp=0/0", busy_o, error_o);
    end
    @(negedge clk_i);
    rst_i = 0; issue_v_i = 0; issue_rd_w_v_i = 0; rs1_v_i = 0; wb_v_i = 0; kill_v_i = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 0;
  endtask

  task automatic test_raw();
    stim_t v [$];
    stim_t t;
    bit es, ee;
    logic [31:0] eb;
    v.push_back(iss(5));
    v.push_back(rd1(5));
    t = rd1(5); t.wbv = 1; t.wbrd = 5; v.push_back(t);
    v.push_back(rd1(5));
    v.push_back(iss(6));
    t = idle(); t.iv = 1; t.r2v = 1; t.r2 = 6; v.push_back(t);
    t.kv = 1; t.krd = 6; v.push_back(t);
    t.kv = 0; v.push_back(t);
    foreach (v[k]) begin
      d(v[k]);
      es = q_s.pop_front(); total++;
      if (stall_v_o !== es) begin bad++; $display("FAIL raw[%0d] stall got=%b exp=%b", k, stall_v_o, es); end
      @(posedge clk_i); #1;
      eb = q_b.pop_front(); ee = q_e.pop_front(); total++;
      if (busy_o !== eb || error_o !== ee) begin
        bad++; $display("FAIL raw[%0d] busy/err got=%h/%b exp=%h/%b", k, busy_o, error_o, eb, ee);
      end
    end
  endtask

  task automatic test_sat();
    stim_t v [$];
    stim_t t;
    bit es, ee;
    logic [31:0] eb;
    repeat (4) v.push_back(iss(7));
    t = iss(7); t.wbv = 1; t.wbrd = 7; v.push_back(t);
    v.push_back(iss(7));
    v.push_back(iss(7));
    repeat (3) v.push_back(wb(7));
    foreach (v[k]) begin
      d(v[k]);
      es = q_s.pop_front(); total++;
      if (stall_v_o !== es) begin bad++; $display("FAIL sat[%0d] stall got=%b exp=%b", k, stall_v_o, es); end
      @(posedge clk_i); #1;
      eb = q_b.pop_front(); ee = q_e.pop_front(); total++;
      if (busy_o !== eb || error_o !== ee) begin
        bad++; $display("FAIL sat[%0d] busy/err got=%h/%b exp=%h/%b", k, busy_o, error_o, eb, ee);
      end
    end
  endtask

  task automatic test_same_cycle();
    stim_t v [$];
    stim_t t;
    bit es, ee;
    logic [31:0] eb;
    v.push_back(iss(9));
    t = iss(9); t.wbv = 1; t.wbrd = 9; v.push_back(t);
    v.push_back(wb(9));
    v.push_back(iss(10));
    v.push_back(iss(10));
    t = wb(10); t.kv = 1; t.krd = 10; v.push_back(t);
    t = idle(); t.iv = 1; t.wv = 1; t.r1v = 1; t.r2v = 1; v.push_back(t);
    t = wb(0); t.kv = 1; t.krd = 0; v.push_back(t);
    foreach (v[k]) begin
      d(v[k]);
      es = q_s.pop_front(); total++;
      if (stall_v_o !== es) begin bad++; $display("FAIL same[%0d] stall got=%b exp=%b", k, stall_v_o, es); end
      @(posedge clk_i); #1;
      eb = q_b.pop_front(); ee = q_e.pop_front(); total++;
      if (busy_o !== eb || error_o !== ee) begin
        bad++; $display("FAIL same[%0d] busy/err got=%h/%b exp=%h/%b", k, busy_o, error_o, eb, ee);
      end
    end
  endtask

  task automatic test_flush();
    stim_t v [$];
    stim_t t;
    bit es, ee;
    logic [31:0] eb;
    v.push_back(iss(11));
    t = rd1(11); t.wv = 1; t.rd = 11; t.fl = 1; v.push_back(t);
    t = rd1(11); t.iv = 0; v.push_back(t);
    v.push_back(wb(11));
    v.push_back(iss(14));
    v.push_back(iss(15));
    v.push_back(iss(16));
    t = rd1(14); t.r2v = 1; t.r2 = 16; v.push_back(t);
    t.wbv = 1; t.wbrd = 14; v.push_back(t);
    t.wbrd = 16; v.push_back(t);
    t.wbv = 0; v.push_back(t);
    t = wb(15); t.kv = 1; t.krd = 31; v.push_back(t);
    foreach (v[k]) begin
      d(v[k]);
      es = q_s.pop_front(); total++;
      if (stall_v_o !== es) begin bad++; $display("FAIL flush[%0d] stall got=%b exp=%b", k, stall_v_o, es); end
      @(posedge clk_i); #1;
      eb = q_b.pop_front(); ee = q_e.pop_front(); total++;
      if (busy_o !== eb || error_o !== ee) begin
        bad++; $display("FAIL flush[%0d] busy/err got=%h/%b exp=%h/%b", k, busy_o, error_o, eb, ee);
      end
    end
  endtask

  task automatic test_error();
    stim_t v [$];
    stim_t t;
    bit es, ee;
    logic [31:0] eb;
    v.push_back(wb(3));
    v.push_back(idle());
    v.push_back(iss(3));
    v.push_back(wb(3));
    foreach (v[k]) begin
      d(v[k]);
      es = q_s.pop_front(); total++;
      if (stall_v_o !== es) begin bad++; $display("FAIL err[%0d] stall got=%b exp=%b", k, stall_v_o, es); end
      @(posedge clk_i); #1;
      eb = q_b.pop_front(); ee = q_e.pop_front(); total++;
      if (busy_o !== eb || error_o !== ee) begin
        bad++; $display("FAIL err[%0d] busy/err got=%h/%b exp=%h/%b", k, busy_o, error_o, eb, ee);
      end
    end
    test_reset();
    v.delete();
    v.push_back(iss(12));
    t = wb(12); t.kv = 1; t.krd = 12; v.push_back(t);
    foreach (v[k]) begin
      d(v[k]);
      es = q_s.pop_front(); total++;
      if (stall_v_o !== es) begin bad++; $display("FAIL dbl[%0d] stall got=%b exp=%b", k, stall_v_o, es); end
      @(posedge clk_i); #1;
      eb = q_b.pop_front(); ee = q_e.pop_front(); total++;
      if (busy_o !== eb || error_o !== ee) begin
        bad++; $display("FAIL dbl[%0d] busy/err got=%h/%b exp=%h/%b", k, busy_o, error_o, eb, ee);
      end
    end
  endtask

`ifdef RVGA_HAZARD_PERF_EN
  task automatic test_perf();
    bit es;
    total++;
    if (stall_cnt_o !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d exp=0", stall_cnt_o); end
    d(iss(13));
    repeat (4) d(rd1(13));
    d(wb(13));
    repeat (6) begin
      es = q_s.pop_front(); void'(q_b.pop_front()); void'(q_e.pop_front());
    end
    @(posedge clk_i); #1 total++;
    if (stall_cnt_o !== 32'd4) begin bad++; $display("FAIL perf_count got=%0d exp=4", stall_cnt_o); end
  endtask
`endif

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 0;
    test_reset();
    test_raw();
    test_sat();
    test_same_cycle();
    test_flush();
    test_error();
    test_reset();
`ifdef RVGA_HAZARD_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
